// File: rtl/message_combiner.sv
// Message combiner: packs N_SLICES consecutive WIDTH-bit slices into one word.
// The first slice goes into the MSBs. Completed words are queued in a circular
// FIFO. Each word is then handed to the consumer through a toggle handshake:
// out_nd flips to present a word, and the consumer sets out_ack equal to
// out_nd to release it.
module message_combiner #(
    parameter int N_SLICES          = 2,
    parameter int LOG_N_SLICES      = 1,
    parameter int WIDTH             = 32,
    parameter int BUFFER_LENGTH     = 32,
    parameter int LOG_BUFFER_LENGTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_nd,
    output logic [WIDTH*N_SLICES-1:0] out_data,
    output logic                      out_nd,
    input  logic                      out_ack,
    output logic                      error
);

    localparam int MSG_W = WIDTH * N_SLICES;
    localparam logic [LOG_N_SLICES-1:0]    LAST_SLICE = LOG_N_SLICES'(N_SLICES - 1);
    localparam logic [LOG_BUFFER_LENGTH-1:0] LAST_PTR = LOG_BUFFER_LENGTH'(BUFFER_LENGTH - 1);
    localparam logic [LOG_BUFFER_LENGTH:0]   FULL_CNT = (LOG_BUFFER_LENGTH + 1)'(BUFFER_LENGTH);

    // The output side is IDLE when the consumer has acknowledged the last toggle.
    typedef enum logic {
        OUT_IDLE,
        OUT_PENDING
    } out_state_e;

    out_state_e                   out_state;

    logic [LOG_N_SLICES-1:0]      slice_cnt_q, slice_cnt_d;
    logic [MSG_W-1:0]             partial_q, partial_d;
    logic [LOG_BUFFER_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_BUFFER_LENGTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_BUFFER_LENGTH:0]   count_q, count_d;
    logic [MSG_W-1:0]             out_data_q, out_data_d;
    logic                         out_nd_q, out_nd_d;
    logic                         error_q, error_d;

    logic [MSG_W-1:0]             mem [BUFFER_LENGTH];
    logic [MSG_W-1:0]             full_word;
    logic                         word_done;
    logic                         wr_en;
    logic                         pop;

    // Next-state logic: slice assembly, FIFO bookkeeping and output handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        slice_cnt_d = slice_cnt_q;
        partial_d   = partial_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_nd_d    = out_nd_q;
        error_d     = error_q;
        word_done   = 1'b0;

        out_state = (out_ack == out_nd_q) ? OUT_IDLE : OUT_PENDING;

        // The last slice lands in the LSBs and bypasses the partial register.
        full_word              = partial_q;
        full_word[WIDTH-1:0]   = in_data;

        if (in_nd) begin
            if (slice_cnt_q == LAST_SLICE) begin
                word_done   = 1'b1;
                slice_cnt_d = '0;
            end else begin
                partial_d[(N_SLICES - 1 - int'(slice_cnt_q)) * WIDTH +: WIDTH] = in_data;
                slice_cnt_d = slice_cnt_q + 1'b1;
            end
        end

        // A word written this edge is not visible to the pop until the next edge.
        pop   = (out_state == OUT_IDLE) && (count_q != '0);
        wr_en = word_done && ((count_q != FULL_CNT) || pop);

        // A full FIFO with no simultaneous pop drops the word; the flag is sticky.
        if (word_done && !wr_en) begin
            error_d = 1'b1;
        end

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            out_data_d = mem[rd_ptr_q];
            out_nd_d   = ~out_nd_q;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            slice_cnt_q <= '0;
            partial_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_nd_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            slice_cnt_q <= slice_cnt_d;
            partial_q   <= partial_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_nd_q    <= out_nd_d;
            error_q     <= error_d;
        end
    end

    // FIFO storage: write the assembled word at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy and pointers alone decide which entries are valid.
        if (wr_en) begin
            mem[wr_ptr_q] <= full_word;
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign error    = error_q;

endmodule
